// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD model: command encodings,
// DDRAM geometry constants and the command decoder.
package lcd_pkg;

    typedef logic [6:0] lcd_addr_t;

    localparam lcd_addr_t  LCD_ROW_STRIDE = 7'h40;
    localparam logic [7:0] LCD_BLANK      = 8'h20;
    localparam logic [7:0] LCD_NEWLINE    = 8'h0A;

    localparam logic [7:0] CMD_SET_DDRAM_MASK = 8'h80;
    localparam logic [7:0] CMD_SET_DDRAM      = 8'h80;
    localparam logic [7:0] CMD_SET_CGRAM_MASK = 8'hC0;
    localparam logic [7:0] CMD_SET_CGRAM      = 8'h40;
    localparam logic [7:0] CMD_HOME_MASK      = 8'hFE;
    localparam logic [7:0] CMD_HOME           = 8'h02;
    localparam logic [7:0] CMD_CLEAR_MASK     = 8'hFF;
    localparam logic [7:0] CMD_CLEAR          = 8'h01;
    localparam logic [7:0] CMD_ENTRY_MASK     = 8'hFC;
    localparam logic [7:0] CMD_ENTRY          = 8'h04;

    typedef enum logic [2:0] {
        LCD_OP_NOP,
        LCD_OP_SET_DDRAM,
        LCD_OP_CGRAM,
        LCD_OP_HOME,
        LCD_OP_CLEAR,
        LCD_OP_ENTRY
    } lcd_op_e;

    // Highest set bit selects the command, so test the widest opcodes first.
    function automatic lcd_op_e lcd_decode(input logic [7:0] c);
        if ((c & CMD_SET_DDRAM_MASK) == CMD_SET_DDRAM) return LCD_OP_SET_DDRAM;
        if ((c & CMD_SET_CGRAM_MASK) == CMD_SET_CGRAM) return LCD_OP_CGRAM;
        if ((c & CMD_ENTRY_MASK) == CMD_ENTRY)         return LCD_OP_ENTRY;
        if ((c & CMD_HOME_MASK) == CMD_HOME)           return LCD_OP_HOME;
        if ((c & CMD_CLEAR_MASK) == CMD_CLEAR)         return LCD_OP_CLEAR;
        return LCD_OP_NOP;
    endfunction

    function automatic logic lcd_addr_valid(input lcd_addr_t a, input int rows, input int cols);
        return (int'(a[5:0]) < cols) && (int'(a[6]) < rows);
    endfunction

endpackage

// File: rtl/lcd_addr_step.sv
// Next DDRAM address for increment, decrement or newline, wrapping across rows
// and around the whole visible area. Purely combinational.
module lcd_addr_step
    import lcd_pkg::*;
#(
    parameter int ROWS = 2,
    parameter int COLS = 16
) (
    input  lcd_addr_t addr,
    input  logic      incr,
    input  logic      newline,
    output lcd_addr_t next
);
    localparam logic [5:0] LAST_COL = 6'(COLS - 1);

    logic       row;
    logic       row_adj;
    logic       row_nx;
    logic [5:0] col;
    logic [5:0] col_nx;

    assign row = addr[6];
    assign col = addr[5:0];
    // With at most two rows, the neighbouring row in either direction is the other one.
    assign row_adj = (ROWS == 2) ? ~row : 1'b0;

    always_comb begin
        row_nx = row;
        col_nx = col;
        if (newline) begin
            row_nx = row_adj;
            col_nx = '0;
        end else if (incr) begin
            if (col >= LAST_COL) begin
                row_nx = row_adj;
                col_nx = '0;
            end else begin
                col_nx = col + 6'd1;
            end
        end else begin
            if (col == '0) begin
                row_nx = row_adj;
                col_nx = LAST_COL;
            end else begin
                col_nx = col - 6'd1;
            end
        end
    end

    assign next = (row_nx ? LCD_ROW_STRIDE : 7'h00) | {1'b0, col_nx};

endmodule

// File: rtl/display_lcd_ctrl.sv
// Clocked HD44780-style character LCD: DDRAM, address counter, busy flag, char-event stream.
// Writes act on the E rising edge (char_valid one clock later); reads are combinational.
// Writes while busy are dropped and flagged; define DISPLAY_LCD_HDB_LOG_EN to mirror chars to the host.
module display_lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int ROWS         = 2,
    parameter int COLS         = 16,
    parameter int BUSY_MODE    = 0,
    parameter int BUSY_CYCLES  = 4,
    parameter int CLEAR_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    inout  wire  [7:0] io_bus,
    input  logic       enable,
    input  logic       rnw,
    input  logic       rs,
    output logic       busy,
    output lcd_addr_t  cursor_addr,
    output logic       char_valid,
    output logic [7:0] char_data,
    output lcd_addr_t  char_addr,
    output logic       drop_err
);
    localparam int         CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int         CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [6:0] FILL_N  = 7'(ROWS * COLS);

    logic             en_q;
    logic             op_rnw;
    logic             op_rs;
    logic             incr;
    logic [CNT_W-1:0] busy_cnt;
    logic [6:0]       fill_cnt;
    lcd_addr_t        fill_addr;
    lcd_addr_t        fill_next;
    lcd_addr_t        ac;
    lcd_addr_t        ac_next;
    logic [7:0]       ddram [128];
    logic [7:0]       rd_dat;
    lcd_op_e          op;

    logic rise, fall, fill_done, expire, wr_req, wr_acc;
    logic cmd_acc, dat_acc, is_nl, store;

    assign rise      = enable & ~en_q;
    assign fall      = ~enable & en_q;
    assign wr_req    = rise & ~rnw;
    assign fill_done = (fill_cnt <= 7'd1);
    // Expiry is evaluated before acceptance so a write landing on the expiry cycle goes through.
    assign expire    = (BUSY_MODE == 0) ? (busy & fill_done & (busy_cnt <= CNT_W'(1)))
                                        : (busy & fill_done & fall & op_rnw & ~op_rs);
    assign wr_acc    = wr_req & (~busy | expire);
    assign cmd_acc   = wr_acc & ~rs;
    assign dat_acc   = wr_acc & rs;
    assign is_nl     = (io_bus == LCD_NEWLINE);
    assign store     = dat_acc & ~is_nl;
    assign op        = lcd_decode(io_bus);

    lcd_addr_step #(.ROWS(ROWS), .COLS(COLS)) u_ac_step (
        .addr    (ac),
        .incr    (incr),
        .newline (dat_acc & is_nl),
        .next    (ac_next)
    );

    lcd_addr_step #(.ROWS(ROWS), .COLS(COLS)) u_fill_step (
        .addr    (fill_addr),
        .incr    (1'b1),
        .newline (1'b0),
        .next    (fill_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q       <= 1'b0;
            op_rnw     <= 1'b0;
            op_rs      <= 1'b0;
            busy       <= 1'b0;
            busy_cnt   <= '0;
            ac         <= '0;
            incr       <= 1'b1;
            fill_cnt   <= '0;
            fill_addr  <= '0;
            char_valid <= 1'b0;
            char_data  <= '0;
            char_addr  <= '0;
            drop_err   <= 1'b0;
        end else begin
            en_q       <= enable;
            char_valid <= store;
            if (rise) begin
                op_rnw <= rnw;
                op_rs  <= rs;
            end
            if (wr_req & ~wr_acc) drop_err <= 1'b1;
            if (busy_cnt != '0) busy_cnt <= busy_cnt - CNT_W'(1);
            if (fill_cnt != '0) begin
                fill_cnt  <= fill_cnt - 7'd1;
                fill_addr <= fill_next;
            end
            if (wr_acc) begin
                busy     <= 1'b1;
                busy_cnt <= CNT_W'(BUSY_CYCLES);
            end else if (expire) begin
                busy <= 1'b0;
            end
            if (store) begin
                char_data <= io_bus;
                char_addr <= ac;
            end
            if (dat_acc) begin
                ac <= ac_next;
            end else if (cmd_acc) begin
                case (op)
                    LCD_OP_SET_DDRAM: ac <= lcd_addr_valid(io_bus[6:0], ROWS, COLS) ? io_bus[6:0] : '0;
                    LCD_OP_HOME:      ac <= '0;
                    LCD_OP_CLEAR: begin
                        ac        <= '0;
                        incr      <= 1'b1;
                        fill_cnt  <= FILL_N;
                        fill_addr <= '0;
                        busy_cnt  <= CNT_W'(CLEAR_CYCLES);
                    end
                    LCD_OP_ENTRY:     incr <= io_bus[1];
                    default:          ;
                endcase
            end else if (fall & op_rnw & op_rs) begin
                ac <= ac_next;
            end
        end
    end

    // DDRAM has no reset: contents survive a reset, including a partially completed clear.
    always_ff @(posedge clk) begin
        if (fill_cnt != '0) ddram[fill_addr] <= LCD_BLANK;
        if (store)          ddram[ac]        <= io_bus;
    end

    assign rd_dat      = rs ? ddram[ac] : {busy, ac};
    assign io_bus      = (enable & rnw) ? rd_dat : 8'bz;
    assign cursor_addr = ac;

`ifdef DISPLAY_LCD_HDB_LOG_EN
    logic nl_log;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) nl_log <= 1'b0;
        else        nl_log <= dat_acc & is_nl;
    end

    always_ff @(posedge clk) begin
        if (char_valid) $write("#FOUT#16#%c", char_data);
        if (nl_log)     $write("#FOUT#16#\n");
    end
`else
    // Without the host log, the char_* ports are the only mirror of the screen.
`endif

endmodule
